// File: rtl/dr_gth_rx_sequencer_pkg.sv
// dr_gth_pkg: shared state encoding and counter widths for the dr_gth RX sequencer.
package dr_gth_pkg;
  localparam int SLIP_CNT_W = 6;
  localparam int RELOCK_CNT_W = 16;
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_RESET       = 3'd1,
    ST_WAIT_LOCK   = 3'd2,
    ST_WAIT_DONE   = 3'd3,
    ST_ALIGN_CHECK = 3'd4,
    ST_SLIP        = 3'd5,
    ST_LOCKED      = 3'd6,
    ST_FAIL        = 3'd7
  } dr_gth_seq_state_t;
endpackage

// File: rtl/dr_gth_rx_sequencer_if.sv
// dr_gth_rx_sequencer_if: GTH RX lane status/control bundle between sequencer (master) and transceiver (slave).
interface dr_gth_rx_sequencer_if;
  logic qpll_lock_i;
  logic rx_cdr_lock_i;
  logic rx_reset_done_i;
  logic pattern_match_i;
  logic gt_rx_reset_o;
  logic gt_rx_userrdy_o;
  logic bitslip_o;
  modport master (
    input  qpll_lock_i, rx_cdr_lock_i, rx_reset_done_i, pattern_match_i,
    output gt_rx_reset_o, gt_rx_userrdy_o, bitslip_o
  );
  modport slave (
    output qpll_lock_i, rx_cdr_lock_i, rx_reset_done_i, pattern_match_i,
    input  gt_rx_reset_o, gt_rx_userrdy_o, bitslip_o
  );
endinterface

// File: rtl/dr_gth_rx_sequencer_sync2.sv
// dr_gth_sync2: two-flop synchroniser for one asynchronous level into the AXI clock domain.
module dr_gth_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clk) sync_q <= !rst_n ? 2'b00 : {sync_q[0], d_i};
  assign q_o = sync_q[1];
endmodule

// File: rtl/dr_gth_rx_sequencer.sv
// dr_gth_rx_sequencer: GTH RX reset/lock/word-alignment bring-up FSM.
// DR_GTH_AUTO_RELOCK_EN: loss of alignment in LOCKED restarts bring-up instead of going to FAIL.
module dr_gth_rx_sequencer
  import dr_gth_pkg::*;
#(
  parameter int unsigned RESET_HOLD   = 16,
  parameter int unsigned LOCK_TIMEOUT = 100000,
  parameter int unsigned SLIP_HOLD    = 4,
  parameter int unsigned SLIP_SETTLE  = 32,
  parameter int unsigned MAX_SLIPS    = 32,
  parameter int unsigned MATCH_GOOD   = 64,
  parameter int unsigned MISS_LIMIT   = 8
) (
  input  logic                    S_AXI_ACLK,
  input  logic                    S_AXI_ARESETN,
  input  logic                    enable_i,
  input  logic                    start_i,
  dr_gth_rx_sequencer_if.master   gt,
  output logic                    aligned_o,
  output logic                    error_o,
  output logic [2:0]              state_o,
  output logic [SLIP_CNT_W-1:0]   slip_count_o,
  output logic [RELOCK_CNT_W-1:0] relock_count_o
);
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + RESET_HOLD + SLIP_SETTLE + SLIP_HOLD + 1);
  localparam int MCNT_W = $clog2(MATCH_GOOD + MISS_LIMIT + 1);
  dr_gth_seq_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic [SLIP_CNT_W-1:0] slip_q, slip_d;
  logic [RELOCK_CNT_W-1:0] relock_q;
  logic error_q, rst_q, rdy_q, bs_q, aligned_q;
  logic bitslip_d, relock_inc;
  logic qpll_s, cdr_s, done_s, match_s, lock_ok;
  dr_gth_sync2 u_sync_qpll (.clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .d_i(gt.qpll_lock_i), .q_o(qpll_s));
  dr_gth_sync2 u_sync_cdr (.clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .d_i(gt.rx_cdr_lock_i), .q_o(cdr_s));
  dr_gth_sync2 u_sync_done (.clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .d_i(gt.rx_reset_done_i), .q_o(done_s));
  dr_gth_sync2 u_sync_match (.clk(S_AXI_ACLK), .rst_n(S_AXI_ARESETN), .d_i(gt.pattern_match_i), .q_o(match_s));
  assign lock_ok = qpll_s & cdr_s;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    mcnt_d = mcnt_q;
    slip_d = slip_q;
    bitslip_d = 1'b0;
    relock_inc = 1'b0;
    if (!enable_i) begin
      state_d = ST_IDLE;
      cnt_d = '0;
      mcnt_d = '0;
    end else if (start_i) begin
      state_d = ST_RESET;
      cnt_d = '0;
      mcnt_d = '0;
      slip_d = '0;
    end else if (!lock_ok && state_q inside {ST_ALIGN_CHECK, ST_SLIP, ST_LOCKED}) begin
      state_d = ST_RESET;
      cnt_d = '0;
      mcnt_d = '0;
      slip_d = '0;
      relock_inc = state_q == ST_LOCKED;
    end else begin
      unique case (state_q)
        ST_RESET: begin
          cnt_d = cnt_q == CNT_W'(RESET_HOLD - 1) ? '0 : cnt_q + 1'b1;
          state_d = cnt_q == CNT_W'(RESET_HOLD - 1) ? ST_WAIT_LOCK : ST_RESET;
        end
        ST_WAIT_LOCK, ST_WAIT_DONE: begin
          if (state_q == ST_WAIT_LOCK ? lock_ok : done_s) begin
            state_d = state_q == ST_WAIT_LOCK ? ST_WAIT_DONE : ST_ALIGN_CHECK;
            cnt_d = '0;
            mcnt_d = '0;
          end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            state_d = ST_FAIL;
            cnt_d = '0;
          end else cnt_d = cnt_q + 1'b1;
        end
        ST_ALIGN_CHECK: begin
          if (cnt_q != CNT_W'(SLIP_SETTLE)) cnt_d = cnt_q + 1'b1;
          else if (!match_s) begin
            state_d = ST_SLIP;
            cnt_d = '0;
            mcnt_d = '0;
          end else if (mcnt_q == MCNT_W'(MATCH_GOOD - 1)) begin
            state_d = ST_LOCKED;
            mcnt_d = '0;
          end else mcnt_d = mcnt_q + 1'b1;
        end
        // First SLIP cycle decides FAIL vs. slip; the pulse then covers cnt 1..SLIP_HOLD.
        ST_SLIP: begin
          if (cnt_q == '0 && slip_q == SLIP_CNT_W'(MAX_SLIPS)) state_d = ST_FAIL;
          else if (cnt_q == CNT_W'(SLIP_HOLD)) begin
            state_d = ST_ALIGN_CHECK;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
            bitslip_d = 1'b1;
            slip_d = cnt_q == '0 ? slip_q + 1'b1 : slip_q;
          end
        end
        ST_LOCKED: begin
          if (match_s) mcnt_d = '0;
          else if (mcnt_q == MCNT_W'(MISS_LIMIT - 1)) begin
            relock_inc = 1'b1;
            mcnt_d = '0;
`ifdef DR_GTH_AUTO_RELOCK_EN
            state_d = ST_RESET;
            cnt_d = '0;
            slip_d = '0;
`else
            state_d = ST_FAIL;
`endif
          end else mcnt_d = mcnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      mcnt_q <= '0;
      slip_q <= '0;
      relock_q <= '0;
      error_q <= 1'b0;
      rst_q <= 1'b1;
      rdy_q <= 1'b0;
      bs_q <= 1'b0;
      aligned_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mcnt_q <= mcnt_d;
      slip_q <= slip_d;
      relock_q <= relock_q + RELOCK_CNT_W'(relock_inc && relock_q != '1);
      error_q <= state_d == ST_FAIL || (error_q && !(enable_i && start_i));
      rst_q <= state_d inside {ST_IDLE, ST_RESET, ST_FAIL};
      rdy_q <= state_d inside {ST_WAIT_DONE, ST_ALIGN_CHECK, ST_SLIP, ST_LOCKED};
      bs_q <= bitslip_d;
      aligned_q <= state_d == ST_LOCKED;
    end
  end
  assign gt.gt_rx_reset_o = rst_q;
  assign gt.gt_rx_userrdy_o = rdy_q;
  assign gt.bitslip_o = bs_q;
  assign aligned_o = aligned_q;
  assign error_o = error_q;
  assign state_o = state_q;
  assign slip_count_o = slip_q;
  assign relock_count_o = relock_q;
endmodule

// File: tb/tb_dr_gth_rx_sequencer.sv
// tb_dr_gth_rx_sequencer: randomized bring-up scenarios checked against an event-level lane model.
module tb_dr_gth_rx_sequencer;
  localparam int LT = 300, RH = 16, SH = 4, SS = 32, MS = 32;
`ifdef DR_GTH_AUTO_RELOCK_EN
  localparam int LOSS_ST = 1;
`else
  localparam int LOSS_ST = 7;
`endif
  logic clk = 1'b0;
  logic rst_n, enable, start;
  logic aligned, error;
  logic [2:0] state;
  logic [5:0] slips;
  logic [15:0] relock;
  logic pm_mode, pm_val;
  int k_target, slips_seen;
  int n_chk, n_err;
  int trace[$], widths[$];
  int prev_st, run, since_fall, min_gap, hold_rst, rst_bad, in_wl, in_wd, slip_bad;
  logic rdy_seen, bs_prev;
  dr_gth_rx_sequencer_if gt_if ();
  assign gt_if.pattern_match_i = pm_mode ? (slips_seen == k_target) : pm_val;
  always #5 clk = ~clk;
  dr_gth_rx_sequencer #(.LOCK_TIMEOUT(LT)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .enable_i(enable), .start_i(start), .gt(gt_if),
    .aligned_o(aligned), .error_o(error), .state_o(state), .slip_count_o(slips), .relock_count_o(relock)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic void clear();
    trace.delete();
    widths.delete();
    prev_st = int'(state);
    slips_seen = 0;
    run = 0;
    since_fall = 1000000;
    min_gap = 1000000;
    hold_rst = 0;
    rst_bad = 0;
    in_wl = 0;
    in_wd = 0;
    slip_bad = 0;
    rdy_seen = 1'b0;
    bs_prev = gt_if.bitslip_o;
  endfunction
  task automatic tick();
    @(negedge clk);
    if (int'(state) != prev_st) trace.push_back(int'(state));
    prev_st = int'(state);
    if (gt_if.bitslip_o) begin
      if (!bs_prev) begin
        slips_seen++;
        if (since_fall < min_gap) min_gap = since_fall;
      end
      run++;
      if (state != 3'd5) slip_bad++;
    end else if (bs_prev) begin
      widths.push_back(run);
      run = 0;
      since_fall = 0;
    end else since_fall++;
    bs_prev = gt_if.bitslip_o;
    if (state == 3'd1 && gt_if.gt_rx_reset_o) hold_rst++;
    if (state inside {[3'd2:3'd6]} && gt_if.gt_rx_reset_o) rst_bad++;
    if (state == 3'd2) in_wl++;
    if (state == 3'd3) in_wd++;
    if (gt_if.gt_rx_userrdy_o) rdy_seen = 1'b1;
  endtask
  task automatic run_seq(input int k, input int ld, input int dd);
    clear();
    k_target = k;
    pm_mode = 1'b1;
    for (int t = 0; t < 6000; t++) begin
      start = t == 0;
      gt_if.qpll_lock_i = t >= ld;
      gt_if.rx_cdr_lock_i = t >= ld;
      gt_if.rx_reset_done_i = t >= dd;
      tick();
      if (state == 3'd6 || state == 3'd7) break;
    end
    start = 1'b0;
  endtask
  task automatic check_seq(input int k);
    int exp_q[$];
    int nk, nbad;
    logic same;
    nk = k < MS ? k : MS;
    exp_q = '{1, 2, 3, 4};
    for (int i = 0; i < nk; i++) begin
      exp_q.push_back(5);
      exp_q.push_back(4);
    end
    if (k < MS) exp_q.push_back(6);
    else begin
      exp_q.push_back(5);
      exp_q.push_back(7);
    end
    same = trace.size() == exp_q.size();
    if (same) foreach (exp_q[i]) if (trace[i] != exp_q[i]) same = 1'b0;
    nbad = 0;
    foreach (widths[i]) if (widths[i] != SH) nbad++;
    chk("trace_len", trace.size(), exp_q.size());
    chk("trace_states", same, 1'b1);
    chk("slip_pulses", widths.size(), nk);
    chk("slip_width_bad", nbad, 0);
    if (nk >= 2) chk("slip_gap_ok", min_gap >= SS, 1'b1);
    chk("reset_hold", hold_rst, RH);
    chk("reset_outside", rst_bad, 0);
    chk("slip_outside", slip_bad, 0);
    chk("slip_count", slips, nk);
    chk("aligned", aligned, k < MS);
    chk("error", error, k >= MS);
    chk("userrdy", gt_if.gt_rx_userrdy_o, k < MS);
  endtask
  task automatic wait_bitslip();
    for (int i = 0; i < 2000 && !gt_if.bitslip_o; i++) tick();
    chk("slip_seen", gt_if.bitslip_o, 1'b1);
  endtask
  initial begin
    int k, ld, dd, rel0, n;
    rst_n = 1'b0;
    enable = 1'b0;
    start = 1'b0;
    pm_mode = 1'b0;
    pm_val = 1'b0;
    k_target = 0;
    gt_if.qpll_lock_i = 1'b0;
    gt_if.rx_cdr_lock_i = 1'b0;
    gt_if.rx_reset_done_i = 1'b0;
    clear();
    repeat (3) tick();
    chk("rst_gt_reset", gt_if.gt_rx_reset_o, 1'b1);
    chk("rst_userrdy", gt_if.gt_rx_userrdy_o, 1'b0);
    chk("rst_bitslip", gt_if.bitslip_o, 1'b0);
    chk("rst_aligned", aligned, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_state", state, 0);
    chk("rst_slips", slips, 0);
    chk("rst_relock", relock, 0);
    rst_n = 1'b1;
    enable = 1'b1;
    tick();
    run_seq(0, 30, 50);
    check_seq(0);
    run_seq(5, $urandom_range(5, 60), $urandom_range(60, 100));
    check_seq(5);
    repeat (3) begin
      k = $urandom_range(0, 8);
      ld = $urandom_range(5, 60);
      dd = ld + $urandom_range(0, 40);
      run_seq(k, ld, dd);
      check_seq(k);
    end
    k = $urandom_range(MS + 1, 200);
    run_seq(k, $urandom_range(5, 40), $urandom_range(40, 80));
    check_seq(k);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_error_clr", error, 1'b0);
    chk("restart_state", state, 1);
    run_seq(0, 1000000, 1000000);
    chk("wl_timeout_state", state, 7);
    chk("wl_timeout_cycles", in_wl, LT);
    chk("wl_timeout_userrdy", rdy_seen, 1'b0);
    chk("wl_timeout_error", error, 1'b1);
    run_seq(0, 1, 1000000);
    chk("wd_timeout_state", state, 7);
    chk("wd_timeout_cycles", in_wd, LT);
    chk("wd_timeout_userrdy", rdy_seen, 1'b1);
    run_seq(0, $urandom_range(1, 30), $urandom_range(30, 60));
    chk("miss_pre_state", state, 6);
    rel0 = int'(relock);
    pm_mode = 1'b0;
    pm_val = 1'b0;
    n = $urandom_range(1, 7);
    repeat (n) tick();
    pm_val = 1'b1;
    repeat (10) tick();
    chk("miss_short_state", state, 6);
    chk("miss_short_relock", relock, rel0);
    clear();
    pm_val = 1'b0;
    n = $urandom_range(8, 12);
    repeat (n) tick();
    pm_val = 1'b1;
    repeat (5) tick();
    chk("miss_long_next", trace.size() > 0 ? trace[0] : -1, LOSS_ST);
    chk("miss_long_relock", relock, rel0 + 1);
    run_seq(0, 1, $urandom_range(1, 20));
    rel0 = int'(relock);
    clear();
    gt_if.qpll_lock_i = 1'b0;
    repeat (3) tick();
    gt_if.qpll_lock_i = 1'b1;
    tick();
    chk("lockloss_locked_next", trace.size() > 0 ? trace[0] : -1, 1);
    chk("lockloss_locked_relock", relock, rel0 + 1);
    for (int i = 0; i < 500 && state != 3'd4; i++) tick();
    chk("align_reached", state, 4);
    gt_if.rx_cdr_lock_i = 1'b0;
    repeat (3) tick();
    gt_if.rx_cdr_lock_i = 1'b1;
    chk("lockloss_align_state", state, 1);
    chk("lockloss_align_relock", relock, rel0 + 1);
    clear();
    pm_mode = 1'b1;
    k_target = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_bitslip();
    enable = 1'b0;
    tick();
    chk("en_low_state", state, 0);
    chk("en_low_bitslip", gt_if.bitslip_o, 1'b0);
    chk("en_low_gt_reset", gt_if.gt_rx_reset_o, 1'b1);
    chk("en_low_userrdy", gt_if.gt_rx_userrdy_o, 1'b0);
    enable = 1'b1;
    clear();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_bitslip();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("abort_slip_state", state, 1);
    chk("abort_slip_bitslip", gt_if.bitslip_o, 1'b0);
    chk("abort_slip_count", slips, 0);
    run_seq(2, 1, 1);
    chk("pre_rst_state", state, 6);
    rst_n = 1'b0;
    tick();
    chk("midrst_state", state, 0);
    chk("midrst_gt_reset", gt_if.gt_rx_reset_o, 1'b1);
    chk("midrst_userrdy", gt_if.gt_rx_userrdy_o, 1'b0);
    chk("midrst_aligned", aligned, 1'b0);
    chk("midrst_slips", slips, 0);
    chk("midrst_relock", relock, 0);
    chk("midrst_error", error, 1'b0);
    rst_n = 1'b1;
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dr_gth_rx_sequencer.md
Name: dr_gth_rx_sequencer

Overview:
Bring-up and alignment controller for the dr_gth receive lane. Runs in the AXI clock domain and sequences the GTH RX reset.
- Waits for PLL lock, CDR lock and reset-done.
- Walks the word boundary with stretched bitslip pulses until the link-pattern detector reports a stable match.
- Monitors the locked link and exposes state, counters and flags to the register map for software bring-up.

Parameters:
RESET_HOLD, 16, cycles gt_rx_reset_o is held asserted
LOCK_TIMEOUT, 100000, max cycles in WAIT_LOCK or WAIT_DONE before FAIL
SLIP_HOLD, 4, cycles bitslip_o stays high per slip (must exceed the RX-domain clock ratio)
SLIP_SETTLE, 32, cycles to wait after a slip before sampling pattern_match
MAX_SLIPS, 32, slips attempted before FAIL (one full 32-bit word)
MATCH_GOOD, 64, consecutive matched cycles required to declare alignment
MISS_LIMIT, 8, consecutive unmatched cycles in LOCKED that count as loss of alignment

Ports:
S_AXI_ACLK  in  1  single clock for the block
S_AXI_ARESETN  in  1  synchronous active-low reset
enable_i  in  1  level; low forces IDLE and deasserts gt_rx_userrdy_o
start_i  in  1  one-cycle pulse; starts or restarts the sequence
qpll_lock_i  in  1  async; synchronised internally with 2 flops
rx_cdr_lock_i  in  1  async; 2-flop synchronised
rx_reset_done_i  in  1  async; 2-flop synchronised
pattern_match_i  in  1  async; 2-flop synchronised; high when USER_DATA matches the alignment word
gt_rx_reset_o  out  1  GTH RX datapath reset
gt_rx_userrdy_o  out  1  RX user-ready to the transceiver
bitslip_o  out  1  stretched slip request
aligned_o  out  1  high only in LOCKED
error_o  out  1  sticky; set on entry to FAIL; cleared by start_i or reset
state_o  out  3  encoded current state
slip_count_o  out  6  slips issued in the current attempt
relock_count_o  out  16  saturating count of alignment losses

Behaviour:
Reset values:
- All outputs 0, except gt_rx_reset_o=1.
- State IDLE; all counters and synchroniser flops 0.

Synchroniser:
- Every decision uses the synchronised inputs, so all inputs carry 2 cycles of latency.

Priority (highest first):
- S_AXI_ARESETN low.
- enable_i low: go to IDLE next cycle; gt_rx_reset_o=1, bitslip_o=0.
- start_i: go to RESET from any state; clear error_o and slip_count_o.

States (state_o encoding):
- IDLE (0): gt_rx_reset_o=1, gt_rx_userrdy_o=0. Leave only on start_i with enable_i high.
- RESET (1): gt_rx_reset_o=1 for exactly RESET_HOLD cycles, then WAIT_LOCK.
- WAIT_LOCK (2): gt_rx_reset_o=0. When qpll and cdr locks are both synchronised high, set gt_rx_userrdy_o=1 and go to WAIT_DONE. Timeout counter reaching LOCK_TIMEOUT goes to FAIL.
- WAIT_DONE (3): when rx_reset_done is high, go to ALIGN_CHECK. Same timeout rule. Timeout counter clears on every state entry.
- ALIGN_CHECK (4):
  - Wait SLIP_SETTLE cycles.
  - Then count consecutive match cycles; any miss goes to SLIP.
  - Reaching MATCH_GOOD goes to LOCKED.
- SLIP (5):
  - If slip_count_o==MAX_SLIPS, go to FAIL.
  - Otherwise bitslip_o=1 for exactly SLIP_HOLD cycles, then 0; increment slip_count_o once (on entry); return to ALIGN_CHECK.
  - bitslip_o is never high outside SLIP.
- LOCKED (6):
  - aligned_o=1.
  - MISS_LIMIT consecutive misses = loss of alignment: relock_count_o increments, saturating at 0xFFFF; next state is set by the macro below.
  - A single match clears the miss counter.
- FAIL (7): error_o=1, gt_rx_reset_o=1, gt_rx_userrdy_o=0. Exit only via start_i or enable_i low.

Loss of lock:
- Dropping qpll or cdr lock in ALIGN_CHECK, SLIP or LOCKED goes to RESET.
- This counts as a relock only when it happens in LOCKED.

Mid-operation events:
- start_i during SLIP aborts the pulse: bitslip_o=0 the next cycle.
- All outputs are registered; no output is combinational from inputs.

Optional Feature:
DR_GTH_AUTO_RELOCK_EN
- Defined: loss of alignment in LOCKED goes to RESET with slip_count_o cleared, i.e. automatic re-bring-up.
- Undefined: loss of alignment goes to FAIL and waits for software start_i. relock_count_o still increments in both builds.

Decomposition:
- Package dr_gth_pkg:
  - state enum type `dr_gth_seq_state_t` (3-bit, encodings as above);
  - width constants `SLIP_CNT_W=6` and `RELOCK_CNT_W=16`.
- Sub-module `dr_gth_sync2`: 2-flop synchroniser, instantiated once per async input (4 instances).

Test Plan:
1. Reset, then enable_i=1, start_i pulse, locks high at cycle 30, reset_done at 50, pattern_match constant 1 -> states 1,2,3,4,6; aligned_o=1; slip_count_o=0; gt_rx_reset_o high exactly 16 cycles.
2. pattern_match_i high only after the 5th slip -> exactly 5 bitslip_o pulses, each 4 cycles wide and ≥32+ cycles apart; slip_count_o=5; LOCKED reached.
3. pattern_match_i never high -> 32 slips, then FAIL with error_o=1; start_i clears error_o and re-enters RESET.
4. Locks held low -> FAIL after 100000 cycles in WAIT_LOCK; gt_rx_userrdy_o stays 0.
5. In LOCKED, drop match for 7 cycles -> stays LOCKED. Drop for 8 cycles -> relock_count_o=1; next state RESET with the macro defined, FAIL without it.
6. enable_i low during SLIP -> next cycle IDLE, bitslip_o=0, gt_rx_reset_o=1. Mid-operation S_AXI_ARESETN low -> all outputs at reset values the following cycle.
